// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: opcodes, ALU/mux selects, FSM states.
// MAIN_CTRL_ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP = 4'd12
`endif
  } state_e;

  // States that stall on the memory handshake and run the wait timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Saturating wait counter with timeout compare; TIMEOUT_CYCLES = 0 disables the timeout.
module mips_mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             TMO_EN  = (TIMEOUT_CYCLES > 0);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: clear has priority over the saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = TMO_EN && inc && (cnt_r == LIMIT);

endmodule

// File: rtl/mips_multicycle_main_ctrl.sv
// Main control FSM of the multi-cycle MIPS core with memory-wait timeout.
// Optional MAIN_CTRL_ILLEGAL_TRAP_EN: unknown opcodes lock in TRAP and raise illegal_op.
module mips_multicycle_main_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALU_Op,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       mem_timeout
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  , output logic     illegal_op
`endif
);

  state_e state_r;
  state_e next_state_s;
  logic   wait_active_s;
  logic   cnt_clear_s;
  logic   timeout_s;

  assign wait_active_s = is_wait_state(state_r) & ~mem_ready;
  // Any state change counts as entry, so the counter starts fresh in every wait state.
  assign cnt_clear_s   = mem_ready | timeout_s | (next_state_s != state_r);

  mips_mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear_s),
    .inc     (wait_active_s),
    .timeout (timeout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state_s = state_r;
    ALU_Op       = ALUOP_ADD;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REGB;
    PCSrc        = PCSRC_ALU;
    pc_en        = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    instr_done   = 1'b0;
    mem_timeout  = 1'b0;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    illegal_op   = 1'b0;
`endif
    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        pc_en   = mem_ready;
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXEC;
          OP_BNE:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDIEX;
          OP_J:         next_state_s = S_JUMP;
          default: begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
            next_state_s = S_TRAP;
`else
            next_state_s = S_FETCH;
            instr_done   = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (opcode == OP_SW) next_state_s = S_MEMWR;
        else                 next_state_s = S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) next_state_s = S_MEMWB;
        else           next_state_s = S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg     = 1'b1;
        RegWrite     = 1'b1;
        instr_done   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          next_state_s = S_FETCH;
          instr_done   = 1'b1;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_EXEC: begin
        ALUSrcA      = 1'b1;
        ALU_Op       = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst       = 1'b1;
        RegWrite     = 1'b1;
        instr_done   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALU_Op       = ALUOP_SUB;
        PCSrc        = PCSRC_ALUOUT;
        pc_en        = ~zero;
        instr_done   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_IMM;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite     = 1'b1;
        instr_done   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        PCSrc        = PCSRC_JUMP;
        pc_en        = 1'b1;
        instr_done   = 1'b1;
        next_state_s = S_FETCH;
      end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_op   = 1'b1;
        next_state_s = S_TRAP;
      end
`endif
      default: next_state_s = S_FETCH;
    endcase

    // An aborted access retires nothing and commits no PC, IR or memory write.
    if (timeout_s) begin
      next_state_s = S_FETCH;
      pc_en        = 1'b0;
      IRWrite      = 1'b0;
      MemWrite     = 1'b0;
      instr_done   = 1'b0;
      mem_timeout  = 1'b1;
    end else begin
      mem_timeout  = 1'b0;
    end

    if (!rst_n) begin
      pc_en       = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      instr_done  = 1'b0;
      mem_timeout = 1'b0;
    end else begin
      RegDst      = RegDst;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_main_ctrl.sv
// Self-checking bench: per-instruction expected traces generated from opcode and wait plans.
module tb_mips_multicycle_main_ctrl;

  localparam int TMO = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALU_Op;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       instr_done, mem_timeout;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  mips_multicycle_main_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALU_Op(ALU_Op), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instr_done(instr_done), .mem_timeout(mem_timeout)
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, mem_timeout;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       mr;
    logic       z;
    logic       chk_done;
    logic       ill;
    outs_t      exp;
  } step_t;

  step_t plan[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  string cur_tag  = "init";

  task automatic push(input logic [5:0] op, input outs_t o, input logic mr, input logic z,
                      input logic chk_done, input logic ill);
    step_t s;
    s.op = op; s.mr = mr; s.z = z; s.chk_done = chk_done; s.ill = ill; s.exp = o;
    plan.push_back(s);
  endtask

  // A wait of n low cycles, then ready; the (TMO+1)-th consecutive low cycle aborts.
  task automatic gen_wait(input logic [5:0] op, input outs_t w, input outs_t r, input outs_t t,
                          input int n, input logic chk, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == TMO) begin
        push(op, t, 1'b0, 1'($urandom_range(0, 1)), chk, 1'b0);
        aborted = 1'b1;
        return;
      end
      push(op, w, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    push(op, r, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  task automatic plain(input logic [5:0] op, input outs_t o);
    push(op, o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  task automatic build(input logic [5:0] op, input int fw, input int mw, input logic z);
    outs_t o, w, r, t;
    bit    ab;
    o = '0; o.mem_read = 1'b1; o.srcb = 2'b01;
    w = o; r = o; r.ir_write = 1'b1; r.pc_en = 1'b1; t = o; t.mem_timeout = 1'b1;
    gen_wait(op, w, r, t, fw, 1'b1, ab);
    if (ab) return;
    o = '0; o.srcb = 2'b11;
    if (!(op inside {T_R, T_LW, T_SW, T_BNE, T_ADDI, T_J})) begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      plain(op, o);
      for (int i = 0; i < 3; i++) push(op, '0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
`else
      o.instr_done = 1'b1;
      plain(op, o);
`endif
      return;
    end
    plain(op, o);
    o = '0;
    case (op)
      T_LW, T_SW: begin
        o.srca = 1'b1; o.srcb = 2'b10;
        plain(op, o);
        if (op == T_LW) begin
          w = '0; w.iord = 1'b1; w.mem_read = 1'b1; r = w; t = w; t.mem_timeout = 1'b1;
          gen_wait(op, w, r, t, mw, 1'b0, ab);
          if (!ab) begin
            o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
            plain(op, o);
          end
        end else begin
          w = '0; w.iord = 1'b1; w.mem_write = 1'b1; r = w; r.instr_done = 1'b1;
          t = '0; t.iord = 1'b1; t.mem_timeout = 1'b1;
          gen_wait(op, w, r, t, mw, 1'b0, ab);
        end
      end
      T_R: begin
        o.srca = 1'b1; o.alu_op = 2'b10;
        plain(op, o);
        o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
        plain(op, o);
      end
      T_BNE: begin
        o.srca = 1'b1; o.alu_op = 2'b01; o.pcsrc = 2'b01; o.pc_en = ~z; o.instr_done = 1'b1;
        push(op, o, 1'($urandom_range(0, 1)), z, 1'b1, 1'b0);
      end
      T_ADDI: begin
        o.srca = 1'b1; o.srcb = 2'b10;
        plain(op, o);
        o = '0; o.reg_write = 1'b1; o.instr_done = 1'b1;
        plain(op, o);
      end
      default: begin
        o.pcsrc = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
        plain(op, o);
      end
    endcase
  endtask

  task automatic check_outs(input string tag, input outs_t e, input logic chk_done, input logic ill);
    outs_t obs;
    obs = {ALU_Op, ALUSrcA, ALUSrcB, PCSrc, pc_en, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, instr_done, mem_timeout};
    if (!chk_done) obs.instr_done = e.instr_done;
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    n_assert++;
    assert (illegal_op === ill) else begin
      n_fail++;
      $error("FAIL %s illegal_op: observed %b expected %b", tag, illegal_op, ill);
    end
`else
    if (ill) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: trap step expected without trap build", tag);
    end
`endif
  endtask

  // Called at a falling edge: drive, settle, check, advance to the next falling edge.
  task automatic execute(input int n);
    step_t s;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      s = plan.pop_front();
      opcode = s.op; mem_ready = s.mr; zero = s.z;
      #1;
      check_outs(cur_tag, s.exp, s.chk_done, s.ill);
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [5:0] op, input int fw, input int mw,
                     input logic z);
    cur_tag = tag;
    build(op, fw, mw, z);
    execute(1000);
  endtask

  outs_t rst_exp;
  step_t s0;
  logic [5:0] ops[7];

  initial begin
    rst_exp = '0; rst_exp.mem_read = 1'b1; rst_exp.srcb = 2'b01;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = T_R;
    #12;
    check_outs("reset_state", rst_exp, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run("rtype", T_R, 0, 0, 1'b0);
    run("lw_wait2", T_LW, 0, 2, 1'b0);
    run("bne_z0", T_BNE, 0, 0, 1'b0);
    run("bne_z1", T_BNE, 0, 0, 1'b1);
    run("sw_timeout", T_SW, 0, 20, 1'b0);
    run("lw_wait_eq_tmo", T_LW, 1, TMO, 1'b0);
    run("fetch_timeout", T_ADDI, 9, 0, 1'b0);
    run("addi", T_ADDI, 2, 0, 1'b0);
    run("jump", T_J, 0, 0, 1'b0);
    run("sw_ok", T_SW, 0, 1, 1'b0);
`ifndef MAIN_CTRL_ILLEGAL_TRAP_EN
    run("unknown_nop", 6'b111111, 0, 0, 1'b0);
`endif

    cur_tag = "async_reset_aluwb";
    build(T_R, 0, 0, 1'b0);
    execute(3);
    s0 = plan.pop_front();
    opcode = s0.op; mem_ready = s0.mr; zero = s0.z;
    #1;
    check_outs("aluwb_before_reset", s0.exp, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("aluwb_async_reset", rst_exp, 1'b1, 1'b0);
    plan.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run("after_reset_j", T_J, 0, 0, 1'b0);

    ops = '{T_R, T_LW, T_SW, T_BNE, T_ADDI, T_J, 6'b111111};
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      int fw;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      op = ops[$urandom_range(0, 5)];
`else
      op = ops[$urandom_range(0, 6)];
`endif
      fw = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 2));
      run("random", op, fw, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    run("trap", 6'b111111, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outs("trap_reset", rst_exp, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_trap", T_R, 0, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
